// File: rtl/pipeline_pkg.sv
// Shared definitions for the unified memory arbiter: FSM state encoding,
// port-owner constants, default widths and the full-word byte-enable mask.
package pipeline_pkg;

  localparam int ADDR_W_DEFAULT = 10;
  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam logic [3:0] BE_WORD = 4'b1111;

  // Increment that sticks at lim.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Grant decision for the IF and MEM ports. MEM wins a tie unless IF has
// already lost STARVE_MAX consecutive ties, in which case IF is forced in.
module mem_arb_select
  import pipeline_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample,
  input  logic       if_req,
  input  logic       mem_req,
  output logic       grant,
  output logic       owner,
  output logic [3:0] starve_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic both;

  // Combinational winner selection; only meaningful while sample is high.
  always_comb begin
    both  = if_req & mem_req;
    grant = sample & (if_req | mem_req);
    if (both) begin
      owner = (starve_cnt == STARVE_LIM) ? OWN_IF : OWN_MEM;
    end else begin
      owner = mem_req ? OWN_MEM : OWN_IF;
    end
  end

  // Count IF losses; an IF grant clears the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (owner == OWN_IF) begin
        starve_cnt <= '0;
      end else if (if_req) begin
        starve_cnt <= sat_inc4(starve_cnt, STARVE_LIM);
      end
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported synchronous RAM between the fetch (IF) and
// load/store (MEM) ports through an IDLE/ISSUE/WAIT/DONE sequence.
// Optional build macro ARB_PERF_CNT_EN adds saturating wait/conflict counters.
//
// Handshake: a port raises req and holds it (with stable fields) until it
// sees its one-cycle ready pulse; fields are latched at grant, rdata is valid
// in the ready cycle and held afterwards; stall = req & ~ready.
module unified_mem_arbiter
  import pipeline_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_be,
  input  logic [DATA_W-1:0] ram_rdata,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_mem_wait,
  output logic [31:0]       perf_conflicts,
`endif
  output state_t            dbg_state,
  output logic [3:0]        dbg_starve_cnt
);

  // WAIT lasts RAM_LAT cycles, so the counter starts at RAM_LAT-1.
  localparam logic [3:0] LAT_LOAD = 4'(RAM_LAT - 1);

  state_t            state, state_n;
  logic [3:0]        lat_cnt, lat_cnt_n;
  logic              owner_q, we_q;
  logic              sample, grant, grant_owner;
  logic              capture;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_be;

  assign sample = (state == ST_IDLE);

  mem_arb_select #(
    .STARVE_MAX(STARVE_MAX)
  ) u_select (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample    (sample),
    .if_req    (if_req),
    .mem_req   (mem_req),
    .grant     (grant),
    .owner     (grant_owner),
    .starve_cnt(dbg_starve_cnt)
  );

  // Fields of the winning port; IF is always a full-word read.
  always_comb begin
    sel_addr  = if_addr;
    sel_we    = 1'b0;
    sel_wdata = '0;
    sel_be    = BE_WORD;
    if (grant_owner == OWN_MEM) begin
      sel_addr  = mem_addr;
      sel_we    = mem_we;
      sel_wdata = mem_wdata;
      sel_be    = mem_we ? mem_be : BE_WORD;
    end
  end

  // Next-state logic; capture marks the edge where read data is valid.
  always_comb begin
    state_n   = state;
    lat_cnt_n = lat_cnt;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant) state_n = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_n = ST_DONE;
        end else begin
          state_n   = ST_WAIT;
          lat_cnt_n = LAT_LOAD;
        end
      end
      ST_WAIT: begin
        if (lat_cnt == 4'd0) begin
          state_n = ST_DONE;
          capture = 1'b1;
        end else begin
          lat_cnt_n = lat_cnt - 4'd1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State register plus the owner/direction latched at grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      lat_cnt <= 4'd0;
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
    end else begin
      state   <= state_n;
      lat_cnt <= lat_cnt_n;
      if (grant) begin
        owner_q <= grant_owner;
        we_q    <= sel_we;
      end
    end
  end

  // RAM strobe registers: loaded on the grant edge so they are live in ISSUE only.
  always_ff @(posedge clk) begin
    if (!rst_n || !grant) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_be    <= 4'b0000;
    end else begin
      ram_en    <= 1'b1;
      ram_we    <= sel_we;
      ram_addr  <= sel_addr;
      ram_wdata <= sel_wdata;
      ram_be    <= sel_be;
    end
  end

  // Read data goes only to the owning port's register and is held afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else if (capture) begin
      if (owner_q == OWN_IF) if_rdata  <= ram_rdata;
      else                   mem_rdata <= ram_rdata;
    end
  end

  assign if_ready  = (state == ST_DONE) && (owner_q == OWN_IF);
  assign mem_ready = (state == ST_DONE) && (owner_q == OWN_MEM);
  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = mem_req & ~mem_ready;
  assign dbg_state = state;

`ifdef ARB_PERF_CNT_EN
  // Saturating performance counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_if_wait   <= '0;
      perf_mem_wait  <= '0;
      perf_conflicts <= '0;
    end else begin
      if (if_stall && perf_if_wait != '1)   perf_if_wait  <= perf_if_wait + 32'd1;
      if (mem_stall && perf_mem_wait != '1) perf_mem_wait <= perf_mem_wait + 32'd1;
      if (sample && if_req && mem_req && perf_conflicts != '1)
        perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule
